// File: rtl/sigmoid_neuron_unit_if.sv
// sigmoid_neuron_unit_if: start/tag/bias, input-beat and result signals of one neuron evaluation.
// Ports: start, sample_idx, neuron_idx, bias, in_valid/in_ready, in_x, in_w (toward the unit);
//        busy, out_valid, act_sum, sig_out, out_sample, out_neuron (from the unit).
// Modports: master (layer sequencer side), slave (neuron unit side).
interface sigmoid_neuron_unit_if #(parameter int DATA_W = 64);
    logic              start;
    logic [15:0]       sample_idx;
    logic [7:0]        neuron_idx;
    logic [DATA_W-1:0] bias;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_w;
    logic              busy;
    logic              out_valid;
    logic [DATA_W-1:0] act_sum;
    logic [DATA_W-1:0] sig_out;
    logic [15:0]       out_sample;
    logic [7:0]        out_neuron;
    modport master (
        output start, sample_idx, neuron_idx, bias, in_valid, in_x, in_w,
        input  in_ready, busy, out_valid, act_sum, sig_out, out_sample, out_neuron
    );
    modport slave (
        input  start, sample_idx, neuron_idx, bias, in_valid, in_x, in_w,
        output in_ready, busy, out_valid, act_sum, sig_out, out_sample, out_neuron
    );
endinterface

// File: rtl/sigmoid_neuron_unit.sv
// sigmoid_neuron_unit: streamed Q32.32 dot product plus bias, followed by a piecewise-linear sigmoid.
// Ports: clk, rst_n (async active-low), bus (sigmoid_neuron_unit_if.slave).
// Macro NEURON_SAT_EN: saturate the product reduction, accumulator add and bias add instead of wrapping.
module sigmoid_neuron_unit #(
    parameter int DATA_W = 64,
    parameter int N_IN   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sigmoid_neuron_unit_if.slave  bus
);
    localparam int P    = 2 * DATA_W;
    localparam int FRAC = DATA_W / 2;
    localparam logic [DATA_W-1:0] L_ONE  = DATA_W'(1) << FRAC;
    localparam logic [DATA_W-1:0] L_HALF = L_ONE >> 1;
    localparam logic [DATA_W-1:0] L_FIVE = DATA_W'(5) << FRAC;
    localparam logic [DATA_W-1:0] L_T2   = (DATA_W'(19) << FRAC) >> 3;
    localparam logic [DATA_W-1:0] L_C2   = (DATA_W'(27) << FRAC) >> 5;
    localparam logic [DATA_W-1:0] L_C1   = (DATA_W'(5) << FRAC) >> 3;
    localparam logic [DATA_W-1:0] L_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACT} state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_acc, r_bias, r_act, r_sig;
    logic [7:0]        r_cnt, r_neuron, r_out_neuron;
    logic [15:0]       r_sample, r_out_sample;
    logic [P-1:0]      w_prod;
    logic [DATA_W-1:0] w_red, w_acc_nx, w_z, w_a, w_y, w_sig;
    logic              w_last, w_take, w_unused;

    assign w_prod = $signed(bus.in_x) * $signed(bus.in_w);

`ifdef NEURON_SAT_EN
    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
        return (a[DATA_W-1] == b[DATA_W-1] && s[DATA_W-1] != a[DATA_W-1]) ? (a[DATA_W-1] ? L_MIN : L_MAX) : s;
    endfunction
    // The shifted product fits in DATA_W bits only if all bits above its sign bit agree.
    logic [DATA_W-FRAC:0] w_hi;
    assign w_hi     = w_prod[P-1:FRAC+DATA_W-1];
    assign w_red    = (&w_hi || !(|w_hi)) ? w_prod[FRAC +: DATA_W] : (w_prod[P-1] ? L_MIN : L_MAX);
    assign w_unused = ^w_prod[FRAC-1:0];
`else
    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return a + b;
    endfunction
    assign w_red    = w_prod[FRAC +: DATA_W];
    assign w_unused = ^{w_prod[P-1:FRAC+DATA_W], w_prod[FRAC-1:0]};
`endif

    assign w_last   = r_cnt == 8'(N_IN - 1);
    assign w_take   = r_state == S_ACCUM && bus.in_valid && !bus.start;
    assign w_acc_nx = f_add(r_acc, w_red);
    // z is formed from the final beat directly so the result is ready in the ACT cycle.
    assign w_z      = f_add(w_acc_nx, r_bias);

    // |z| taken as unsigned so the most negative value still lands in the saturated segment.
    assign w_a   = w_z[DATA_W-1] ? -w_z : w_z;
    assign w_y   = (w_a >= L_FIVE) ? L_ONE :
                   (w_a >= L_T2)   ? (w_a >> 5) + L_C2 :
                   (w_a >= L_ONE)  ? (w_a >> 3) + L_C1 : (w_a >> 2) + L_HALF;
    assign w_sig = w_z[DATA_W-1] ? L_ONE - w_y : w_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.start)                w_next = S_ACCUM;
        else if (r_state == S_ACCUM)  w_next = (bus.in_valid && w_last) ? S_ACT : S_ACCUM;
        else if (r_state == S_ACT)    w_next = S_IDLE;
    end

    always_comb begin
        bus.in_ready  = r_state == S_ACCUM;
        bus.busy      = r_state != S_IDLE;
        bus.out_valid = r_state == S_ACT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_bias       <= '0;
            r_sample     <= '0;
            r_neuron     <= '0;
            r_act        <= '0;
            r_sig        <= '0;
            r_out_sample <= '0;
            r_out_neuron <= '0;
        end else if (bus.start) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bias   <= bus.bias;
            r_sample <= bus.sample_idx;
            r_neuron <= bus.neuron_idx;
        end else if (w_take) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
                r_act        <= w_z;
                r_sig        <= w_sig;
                r_out_sample <= r_sample;
                r_out_neuron <= r_neuron;
            end
        end
    end

    assign bus.act_sum    = r_act;
    assign bus.sig_out    = r_sig;
    assign bus.out_sample = r_out_sample;
    assign bus.out_neuron = r_out_neuron;
endmodule

// File: tb/tb_sigmoid_neuron_unit.sv
// tb_sigmoid_neuron_unit: directed vectors with hand-computed results for sigmoid_neuron_unit.
module tb_sigmoid_neuron_unit;
    localparam int N = 15;
    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] QTR  = 64'h0000_0000_4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ov = 0;
    int   base;

    sigmoid_neuron_unit_if #(.DATA_W(64)) bus ();
    sigmoid_neuron_unit #(.DATA_W(64), .N_IN(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.out_valid) n_ov++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".rdy"}, 64'(bus.in_ready), 0);
        check({tag, ".busy"}, 64'(bus.busy), 0);
        check({tag, ".ov"}, 64'(bus.out_valid), 0);
        check({tag, ".act"}, bus.act_sum, 0);
        check({tag, ".sig"}, bus.sig_out, 0);
        check({tag, ".smp"}, 64'(bus.out_sample), 0);
        check({tag, ".nrn"}, 64'(bus.out_neuron), 0);
    endtask

    // in_valid is raised with start on purpose: that beat must not be counted.
    task automatic do_start(input logic [63:0] b, input logic [15:0] s, input logic [7:0] n);
        bus.start = 1'b1; bus.bias = b; bus.sample_idx = s; bus.neuron_idx = n;
        bus.in_valid = 1'b1; bus.in_x = ONE; bus.in_w = ONE;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("start.rdy", 64'(bus.in_ready), 1);
    endtask

    task automatic beats(input int k, input logic [63:0] x, input logic [63:0] w, input bit gap);
        for (int i = 0; i < k; i++) begin
            if (gap) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                check("gap.busy", 64'(bus.busy), 1);
            end
            bus.in_valid = 1'b1; bus.in_x = x; bus.in_w = w;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [63:0] act, input logic [63:0] sig,
                          input logic [15:0] s, input logic [7:0] n);
        check({tag, ".ov"}, 64'(bus.out_valid), 1);
        check({tag, ".act"}, bus.act_sum, act);
        check({tag, ".sig"}, bus.sig_out, sig);
        check({tag, ".smp"}, 64'(bus.out_sample), 64'(s));
        check({tag, ".nrn"}, 64'(bus.out_neuron), 64'(n));
        @(negedge clk);
        check({tag, ".ovfall"}, 64'(bus.out_valid), 0);
    endtask

    task automatic eval(input string tag, input logic [63:0] b, input logic [63:0] x, input logic [63:0] w,
                        input bit gap, input logic [63:0] act, input logic [63:0] sig);
        do_start(b, 16'(n_cmp), 8'(n_cmp + 3));
        beats(N, x, w, gap);
        result(tag, act, sig, 16'(n_cmp - 3), 8'(n_cmp));
    endtask

    initial begin
        bus.start = 0; bus.bias = 0; bus.sample_idx = 0; bus.neuron_idx = 0;
        bus.in_valid = 0; bus.in_x = 0; bus.in_w = 0;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        do_start(64'h0, 16'h1234, 8'h56);
        beats(N, 64'h0, 64'h0, 1'b0);
        result("zero", 64'h0, HALF, 16'h1234, 8'h56);
        do_start(64'hFFFF_FFF1_8000_0000, 16'h0002, 8'h07);
        beats(N, ONE, ONE, 1'b0);
        result("half", 64'h0000_0000_8000_0000, 64'h0000_0000_A000_0000, 16'h0002, 8'h07);
        do_start(64'h0000_0008_0000_0000, 16'h0003, 8'h08);
        beats(N, 64'h0, 64'h0, 1'b0);
        result("p8", 64'h0000_0008_0000_0000, ONE, 16'h0003, 8'h08);
        do_start(64'hFFFF_FFFF_8000_0000, 16'h0004, 8'h09);
        beats(N, 64'h0, 64'h0, 1'b0);
        result("m05", 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_6000_0000, 16'h0004, 8'h09);
        do_start(64'hFFFF_FFF8_0000_0000, 16'h0005, 8'h0A);
        beats(N, 64'h0, 64'h0, 1'b0);
        result("m8", 64'hFFFF_FFF8_0000_0000, 64'h0, 16'h0005, 8'h0A);
        do_start(64'hFFFF_FFFD_0000_0000, 16'h0006, 8'h0B);
        beats(N, 64'h0, 64'h0, 1'b0);
        result("m3", 64'hFFFF_FFFD_0000_0000, 64'h0000_0000_1000_0000, 16'h0006, 8'h0B);
        do_start(64'h0000_000C_0000_0000, 16'h0007, 8'h0C);
        beats(N, 64'hFFFF_FFFE_8000_0000, HALF, 1'b0);
        result("negprod", 64'h0000_0000_C000_0000, 64'h0000_0000_B000_0000, 16'h0007, 8'h0C);
        do_start(64'h0, 16'h0008, 8'h0D);
        beats(N, HALF, QTR, 1'b1);
        result("gap", 64'h0000_0001_E000_0000, 64'h0000_0000_DC00_0000, 16'h0008, 8'h0D);
        do_start(64'h7FFF_FFFF_0000_0000, 16'h0009, 8'h0E);
        beats(N, ONE, ONE, 1'b0);
`ifdef NEURON_SAT_EN
        result("sat", 64'h7FFF_FFFF_FFFF_FFFF, ONE, 16'h0009, 8'h0E);
`else
        result("wrap", 64'h8000_000E_0000_0000, 64'h0, 16'h0009, 8'h0E);
`endif
        bus.in_valid = 1'b1; bus.in_x = ONE; bus.in_w = ONE;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle.rdy", 64'(bus.in_ready), 0);
        check("idle.busy", 64'(bus.busy), 0);
        check("idle.ov", 64'(bus.out_valid), 0);
        check("idle.smp", 64'(bus.out_sample), 64'h0009);
        base = n_ov;
        do_start(64'h0000_0005_0000_0000, 16'hAAAA, 8'h11);
        beats(7, ONE, ONE, 1'b0);
        check("abort.ov", 64'(bus.out_valid), 0);
        do_start(64'hFFFF_FFF1_8000_0000, 16'hBEEF, 8'h22);
        beats(N, ONE, ONE, 1'b0);
        result("abort", 64'h0000_0000_8000_0000, 64'h0000_0000_A000_0000, 16'hBEEF, 8'h22);
        check("abort.count", 64'(n_ov - base), 1);
        base = n_ov;
        do_start(64'h0, 16'h0033, 8'h44);
        beats(5, ONE, ONE, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        beats(12, ONE, ONE, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst.count", 64'(n_ov - base), 0);
        check("midrst.busy", 64'(bus.busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sigmoid_neuron_unit.md
# sigmoid_neuron_unit

Single-neuron evaluation block for the forward-propagation datapath. It accumulates a streamed dot product of inputs and weights (the weighted-sum path), adds a per-neuron bias (the bias path), and applies a piecewise-linear sigmoid to the sum. It sits between the weight/input memories and the layer sequencer, which issues one `start` per (sample, neuron) pair.

## Interface
- `DATA_W`, 64: word width, signed fixed-point Q32.32.
- `N_IN`, 15: input beats per neuron evaluation (1..255).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin evaluation; latches `bias`, `sample_idx`, `neuron_idx`.
- `sample_idx` input 16: sample tag, echoed on `out_sample`.
- `neuron_idx` input 8: neuron tag, echoed on `out_neuron`.
- `bias` input DATA_W: bias term, Q32.32.
- `in_valid` input 1: `in_x` and `in_w` are valid this cycle.
- `in_ready` output 1: high while accumulating.
- `in_x` input DATA_W: input activation, Q32.32.
- `in_w` input DATA_W: weight, Q32.32.
- `busy` output 1: evaluation in progress.
- `out_valid` output 1: one-cycle pulse; result valid.
- `act_sum` output DATA_W: z = dot product + bias, Q32.32.
- `sig_out` output DATA_W: sigmoid(z), Q32.32, range [0, 1.0].
- `out_sample` output 16: captured sample tag.
- `out_neuron` output 8: captured neuron tag.

## Operation
- The block has three states: IDLE, ACCUM and ACT.
- IDLE: `in_ready`=0 and `busy`=0.
  - `start`=1: clear the accumulator and beat counter, latch bias and tags, go to ACCUM.
- ACCUM: `in_ready`=1 and `busy`=1.
  - Each accepted beat (`in_valid`=1) forms the signed 128-bit product of `in_x` and `in_w`.
  - The product is arithmetic-shifted right by 32, reduced to 64 bits and added to the accumulator.
  - The beat counter increments on each accepted beat. The N_IN-th beat moves the state to ACT.
- ACT: z = acc + bias, registered to `act_sum`. `sig_out` = f(z), registered. `out_valid`=1 for one cycle, then the state returns to IDLE.
- Sigmoid f (PLAN approximation), with a = |z|:
  - a ≥ 5.0: y = 1.0.
  - 2.375 ≤ a < 5.0: y = a/32 + 0.84375.
  - 1.0 ≤ a < 2.375: y = a/8 + 0.625.
  - a < 1.0: y = a/4 + 0.5.
  - z < 0: result = 1.0 − y. Otherwise result = y.
  - Divisions are arithmetic right shifts. No multipliers are used in the sigmoid.
- `start` in ACCUM or ACT aborts the current evaluation and restarts from the new inputs. No `out_valid` is produced for the aborted evaluation.
- `in_valid` outside ACCUM is ignored.
- If `start` and `in_valid` are both high in IDLE, only the start is taken.
- `act_sum`, `sig_out` and the tag outputs hold their values until the next ACT.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, accumulator=0, counter=0, and every output = 0. This includes `in_ready`, `busy`, `out_valid`, `act_sum`, `sig_out`, `out_sample` and `out_neuron`.
- A reset asserted mid-evaluation discards it; no `out_valid` is produced.
- `in_ready` rises the cycle after the edge that samples `start`.
- Latency: `out_valid` is high in the cycle following the edge that accepted the N_IN-th beat. It falls one cycle later.
- Throughput: one beat per cycle. `start` may be asserted in the same cycle `out_valid` is high.

## Configuration
- Macro `NEURON_SAT_EN`.
- Defined: the accumulator add, the bias add and the 128→64 product reduction saturate to +0x7FFF_FFFF_FFFF_FFFF / −0x8000_0000_0000_0000.
- Undefined: all three wrap modulo 2^64 (two's complement).
- The sigmoid is unaffected by the macro.

## Test plan
- Zero inputs, `bias`=0, N_IN beats of x=0 → `act_sum`=0, `sig_out`=0x0000_0000_8000_0000 (0.5), `out_valid` one cycle after the last beat.
- 15 beats of x=w=0x1_0000_0000 (1.0), `bias`=−14.5 (0xFFFF_FFF1_8000_0000) → z=0.5, `sig_out`=0x0000_0000_A000_0000 (0.625).
- Zero inputs, `bias` of +8.0 / −0.5 / −8.0 → `sig_out` of 0x1_0000_0000 / 0x0000_0000_6000_0000 / 0.
- `bias`=0x7FFF_FFFF_0000_0000, beats of x=w=1.0 → with `NEURON_SAT_EN`, `act_sum`=0x7FFF_FFFF_FFFF_FFFF and `sig_out`=1.0; without it, z wraps negative and `sig_out`=0.
- Abort and reset:
  - `start` after 7 beats, then 15 fresh beats → exactly one `out_valid`, with the new tags.
  - `rst_n` low mid-ACCUM → all outputs 0 and no `out_valid`.
- `in_valid` gaps (valid every other cycle) → same result as back-to-back beats; `busy` stays high throughout.
